// File: rtl/spi_master_param_if.sv
// Command-side bus between the sequencer and spi_master_param: start/busy/done
// handshake, per-transfer settings and the received word.
interface spi_master_param_if #(
  parameter int DATA_W = 8,
  parameter int CS_W   = 1
);
  logic              i_start;
  logic [1:0]        i_mode;
  logic [CS_W-1:0]   i_cs_sel;
  logic              i_hold;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_busy;
  logic              o_done;

  // master: the command sequencer; slave: the SPI engine
  modport master (output i_start, i_mode, i_cs_sel, i_hold, i_wdata,
                  input  o_rdata, o_busy, o_done);
  modport slave  (input  i_start, i_mode, i_cs_sel, i_hold, i_wdata,
                  output o_rdata, o_busy, o_done);
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: run-time CPOL/CPHA, configurable word width, clock
// divider and chip-select count, with optional CS hold across multi-word frames.
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_CS  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_master_param_if.slave s_bus,
  output logic              o_clk,
  output logic              o_mosi,
  input  logic              i_miso,
  output logic [NUM_CS-1:0] o_cs
);
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] EDGE_PEN  = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [EDGE_W-1:0]   r_edge;
  logic                r_cpha;
  logic [DATA_W-1:0]   r_tx, r_rx, r_rdata;
  logic                r_sclk, r_mosi, r_done;
  logic [NUM_CS-1:0]   r_cs, w_cs_sel;
  logic                w_tick, w_accept, w_fire, w_to_trail, w_fin;
  logic                w_sample_phase, w_sample, w_drive;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    w_to_trail  = 1'b0;
    w_fin       = 1'b0;
    w_tick      = (r_cnt == CNT_LAST);
    case (r_state)
      IDLE:  if (s_bus.i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = LEAD;
             end
      LEAD:  if (w_tick) begin
               w_fire      = 1'b1;
               w_state_nxt = XFER;
             end
      XFER:  if (w_tick) begin
               if (r_edge == EDGE_LAST) begin
                 w_to_trail  = 1'b1;
                 w_fin       = (CLK_DIV == 1);
                 w_state_nxt = TRAIL;
               end else begin
                 w_fire = 1'b1;
               end
             end
      TRAIL: begin
               // done/rdata are registered, so they are launched one cycle before TRAIL ends
               if (CLK_DIV > 1 && r_cnt == CNT_PRE) w_fin = 1'b1;
               if (w_tick) w_state_nxt = IDLE;
             end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Edge being fired is r_edge+1: odd when r_edge[0]=0. CPHA=0 samples odd edges, CPHA=1 even.
  assign w_sample_phase = ~r_edge[0] ^ r_cpha;
  assign w_sample       = w_fire & w_sample_phase;
  assign w_drive        = w_fire & ~w_sample_phase & (r_cpha | (r_edge != EDGE_PEN));

  always_comb begin
    w_cs_sel = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (s_bus.i_cs_sel == CS_W'(i)) w_cs_sel[i] = 1'b0;
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt   <= '0;
      r_edge  <= '0;
      r_cpha  <= 1'b0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b1;
      r_done  <= 1'b0;
      r_cs    <= '1;
    end else begin
      r_done <= w_fin;
      r_cnt  <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (w_accept) begin
        r_edge <= '0;
        r_cpha <= s_bus.i_mode[0];
        r_sclk <= s_bus.i_mode[1];
        r_rx   <= '0;
        r_cs   <= w_cs_sel;
        // CPHA=0 presents the MSB for the whole lead-in; CPHA=1 drives it on edge 1
        r_tx   <= s_bus.i_mode[0] ? s_bus.i_wdata : (s_bus.i_wdata << 1);
        r_mosi <= s_bus.i_mode[0] ? 1'b1 : s_bus.i_wdata[DATA_W-1];
      end else begin
        if (w_fire) begin
          r_edge <= r_edge + 1'b1;
          r_sclk <= ~r_sclk;
        end
        if (w_drive) begin
          r_mosi <= r_tx[DATA_W-1];
          r_tx   <= r_tx << 1;
        end
        if (w_sample) r_rx <= {r_rx[DATA_W-2:0], i_miso};
        if (w_to_trail) r_mosi <= 1'b1;
        if (w_fin) r_rdata <= r_rx;
        if (!s_bus.i_hold && (r_state == IDLE || (r_state == TRAIL && w_tick)))
          r_cs <= '1;
      end
    end
  end

  assign s_bus.o_busy  = (r_state != IDLE);
  assign s_bus.o_done  = r_done;
  assign s_bus.o_rdata = r_rdata;
  assign o_clk  = r_sclk;
  assign o_mosi = r_mosi;
  assign o_cs   = r_cs;
endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: an 8-bit/div-4/4-CS instance with a mode-aware
// SPI slave model or loopback, plus a 16-bit/div-1 instance in loopback.
module tb_spi_master_param;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(8),  .CS_W(2)) a_if ();
  spi_master_param_if #(.DATA_W(16), .CS_W(1)) b_if ();

  logic [3:0] a_cs;
  logic       a_sclk, a_mosi, a_miso;
  logic [0:0] b_cs;
  logic       b_sclk, b_mosi, b_miso;

  spi_master_param #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .s_bus(a_if),
    .o_clk(a_sclk), .o_mosi(a_mosi), .i_miso(a_miso), .o_cs(a_cs));

  spi_master_param #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .s_bus(b_if),
    .o_clk(b_sclk), .o_mosi(b_mosi), .i_miso(b_miso), .o_cs(b_cs));

  int checks = 0;
  int failures = 0;
  logic [7:0]  sb_a[$];
  logic [15:0] sb_b[$];
  logic [7:0]  last_rd_a = 8'h00;

  // SPI slave model: shifts out on the non-sampling edge, captures MOSI on the sampling edge
  int         s_load_cnt = 0;
  int         s_seen = 0;
  logic [7:0] s_word = 8'h00, s_tx = 8'h00, s_rx = 8'h00;
  logic       s_miso = 1'b1, s_arm = 1'b0, s_cpol = 1'b0, s_cpha = 1'b0, s_loop = 1'b1;

  always @(a_sclk or s_load_cnt) begin
    if (s_load_cnt != s_seen) begin
      s_seen = s_load_cnt;
      s_tx   = s_word;
      s_rx   = 8'h00;
      s_miso = s_word[7];
    end else if (s_arm) begin
      if (a_sclk !== s_cpol) begin
        if (s_cpha) begin s_miso = s_tx[7]; s_tx = s_tx << 1; end
        else s_rx = {s_rx[6:0], a_mosi};
      end else begin
        if (s_cpha) s_rx = {s_rx[6:0], a_mosi};
        else begin s_tx = s_tx << 1; s_miso = s_tx[7]; end
      end
    end
  end

  assign a_miso = s_loop ? a_mosi : s_miso;
  assign b_miso = b_mosi;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [7:0] wd, input logic [1:0] md, input logic [1:0] sel,
                       input logic hold_v, input logic loop, input logic [7:0] slave_word,
                       input int abort_edge, input bit poke);
    int n, edges;
    logic prev_clk, cs_ok;
    logic [3:0] exp_cs;
    logic [7:0] exp_pop;
    exp_cs = 4'hF;
    exp_cs[sel] = 1'b0;
    s_loop = loop; s_cpol = md[1]; s_cpha = md[0]; s_word = slave_word; s_arm = 1'b0;
    s_load_cnt++;
    a_if.i_wdata = wd; a_if.i_mode = md; a_if.i_cs_sel = sel; a_if.i_hold = hold_v;
    a_if.i_start = 1'b1;
    sb_a.push_back(loop ? wd : slave_word);
    tick();
    a_if.i_start = 1'b0;
    s_arm = 1'b1;
    check("busy_at_accept", a_if.o_busy, 1);
    check("cs_select", a_cs, exp_cs);
    check("sclk_cpol_lead", a_sclk, md[1]);
    check("rdata_hold", a_if.o_rdata, last_rd_a);
    n = 1; edges = 0; prev_clk = a_sclk; cs_ok = 1'b1;
    while (!a_if.o_done && n < 200) begin
      tick();
      n++;
      if (a_sclk !== prev_clk) edges++;
      prev_clk = a_sclk;
      if (a_cs !== exp_cs) cs_ok = 1'b0;
      if (abort_edge != 0 && edges == abort_edge) begin
        rst_n = 1'b0;
        #1;
        check("rst_cs", a_cs, 4'hF);
        check("rst_sclk", a_sclk, 0);
        check("rst_busy", a_if.o_busy, 0);
        check("rst_mosi", a_mosi, 1);
        void'(sb_a.pop_back());
        last_rd_a = 8'h00;
        s_arm = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      a_if.i_start = (poke && n == 20);
    end
    s_arm = 1'b0;
    check("done_cycle", n, 72);
    check("sclk_edges", edges, 16);
    check("cs_steady", cs_ok, 1);
    check("mosi_at_sample", s_rx, wd);
    check("sclk_idle", a_sclk, md[1]);
    if (sb_a.size() != 0) begin
      exp_pop = sb_a.pop_front();
      check("rdata", a_if.o_rdata, exp_pop);
      last_rd_a = exp_pop;
    end
    a_if.i_start = poke;
    tick();
    a_if.i_start = 1'b0;
    check("busy_after_done", a_if.o_busy, 0);
    check("mosi_idle", a_mosi, 1);
    check("cs_after", a_cs, hold_v ? exp_cs : 4'hF);
  endtask

  task automatic run_b(input logic [15:0] wd, input logic [1:0] md);
    int n;
    logic [15:0] exp_pop;
    b_if.i_wdata = wd; b_if.i_mode = md; b_if.i_start = 1'b1;
    sb_b.push_back(wd);
    tick();
    b_if.i_start = 1'b0;
    check("b_busy", b_if.o_busy, 1);
    check("b_cs", b_cs, 0);
    n = 1;
    while (!b_if.o_done && n < 100) begin
      tick();
      n++;
    end
    check("b_done_cycle", n, 34);
    if (sb_b.size() != 0) begin
      exp_pop = sb_b.pop_front();
      check("b_rdata", b_if.o_rdata, exp_pop);
    end
    tick();
    check("b_sclk_idle", b_sclk, md[1]);
    check("b_cs_after", b_cs, 1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    a_if.i_start = 1'b0; a_if.i_mode = 2'd0; a_if.i_cs_sel = 2'd0; a_if.i_hold = 1'b0;
    a_if.i_wdata = 8'h00;
    b_if.i_start = 1'b0; b_if.i_mode = 2'd0; b_if.i_cs_sel = 1'b0; b_if.i_hold = 1'b0;
    b_if.i_wdata = 16'h0000;
    repeat (3) tick();
    check("reset_cs", a_cs, 4'hF);
    check("reset_sclk", a_sclk, 0);
    check("reset_mosi", a_mosi, 1);
    check("reset_busy", a_if.o_busy, 0);
    check("reset_done", a_if.o_done, 0);
    check("reset_rdata", a_if.o_rdata, 0);
    check("reset_b_cs", b_cs, 1);
    rst_n = 1'b1;
    tick();

    // Mode 0 loopback
    run_a(8'hA5, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00, 0, 1'b0);

    // All four modes against the slave model
    for (int m = 0; m < 4; m++)
      run_a(8'hC3, 2'(m), 2'd0, 1'b0, 1'b0, 8'h3C, 0, 1'b0);

    // CS hold across a two-word frame on device 2
    run_a(8'hFF, 2'd0, 2'd2, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    ok = 1'b1;
    repeat (6) begin
      tick();
      if (a_cs !== 4'b1011) ok = 1'b0;
    end
    check("cs_held_idle", ok, 1);
    run_a(8'h40, 2'd0, 2'd2, 1'b1, 1'b1, 8'h00, 0, 1'b0);
    a_if.i_hold = 1'b0;
    check("cs_hold_same_cycle", a_cs, 4'b1011);
    tick();
    check("cs_release", a_cs, 4'hF);

    // Ignored starts mid-transfer and in the done cycle, then back-to-back accept
    run_a(8'h5A, 2'd0, 2'd1, 1'b0, 1'b1, 8'h00, 0, 1'b1);
    run_a(8'h96, 2'd1, 2'd1, 1'b0, 1'b1, 8'h00, 0, 1'b0);

    // Reset at SCLK edge 5, then a clean transfer
    run_a(8'h3C, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00, 5, 1'b0);
    run_a(8'h81, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00, 0, 1'b0);

    // 16-bit, divide-by-1 instance
    run_b(16'h1234, 2'd0);
    run_b(16'hBEEF, 2'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
